ram_block_mover: RTL
====================

Name: ram_block_mover

Overview:
- Bus-master sequencer for the 64x8 data RAM, driving the RAM's clk/write_enable/address/input_data side and consuming output_data.
- Executes block commands (FILL, COPY, SUM) issued over a valid/ready command port, e.g. by test/boot logic or the accumulator core, while the core is stalled.
- Pairs with the existing ram block; address/data widths match it.

Parameters:
- ADDR_WIDTH, 6, RAM address width (depth 2^ADDR_WIDTH)
- DATA_WIDTH, 8, RAM data width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command (high only in IDLE)
- cmd_op  input  2  00 FILL, 01 COPY, 10 SUM, 11 reserved
- cmd_src  input  ADDR_WIDTH  source start address (COPY, SUM)
- cmd_dst  input  ADDR_WIDTH  destination start address (FILL, COPY)
- cmd_len  input  ADDR_WIDTH+1  byte count, 0..64
- cmd_data  input  DATA_WIDTH  fill value (FILL)
- busy  output  1  command in progress (not IDLE)
- done  output  1  one-cycle pulse on completion
- err  output  1  last command was reserved op; held until next accept
- result  output  DATA_WIDTH  SUM result, mod 2^DATA_WIDTH; held until next SUM accept
- ram_address  output  ADDR_WIDTH  to ram address
- ram_write_enable  output  1  to ram write_enable
- ram_input_data  output  DATA_WIDTH  to ram input_data
- ram_output_data  input  DATA_WIDTH  from ram output_data

Behaviour:
- RAM contract: read combinational (output_data valid same cycle as address); write at rising clk edge when write_enable=1.
- Reset (sync): state IDLE, cmd_ready=1, busy=0, done=0, err=0, result=0, ram_write_enable=0, ram_address=0, ram_input_data=0, counters cleared. Reset mid-command aborts at that edge; writes already committed remain, no further writes.
- Accept: rising edge with cmd_valid & cmd_ready latches op/src/dst/len/data, sets index i=0, clears err. Accepting SUM clears result. Inputs ignored while busy.
- States: IDLE, FILL, COPY_RD, COPY_WR, SUM, DONE.
- IDLE -> FILL/COPY_RD/SUM per op on accept. len=0 or op=11 -> DONE directly; no RAM access. op=11 also sets err.
- FILL: each cycle address=dst+i, write_enable=1, input_data=data; i++. After i reaches len-1 -> DONE. N bytes take N cycles.
- COPY_RD: address=src+i, write_enable=0; capture output_data into buffer at edge -> COPY_WR.
- COPY_WR: address=dst+i, write_enable=1, input_data=buffer; i++. Goes to COPY_RD, or to DONE after the last byte. 2 cycles per byte.
- Copy order is always ascending. Overlap with dst>src replicates the source pattern; this is defined behaviour, not an error.
- SUM: address=src+i, write_enable=0; result += output_data at edge (mod 2^DATA_WIDTH). 1 cycle per byte.
- Address arithmetic is mod 2^ADDR_WIDTH: start+i wraps 63->0. len=64 touches every location exactly once.
- DONE: done=1, busy=1, cmd_ready=0, write_enable=0 for exactly one cycle -> IDLE.
- Earliest next accept is the cycle after DONE. Throughput per command = 1 (accept) + access cycles + 1 (DONE).
- Outside FILL/COPY_WR, ram_write_enable=0. ram_address/ram_input_data are don't-care when not accessing; drive 0 in IDLE.
- busy = state != IDLE; cmd_ready = state == IDLE.
- Simultaneous reset and cmd_valid: reset wins, no accept.

Test Plan:
- Reset then FILL dst=10, len=4, data=0xA5 -> writes at addresses 10,11,12,13 on 4 consecutive cycles; done pulses once; RAM[9]/RAM[14] unchanged; 0xA5 read back at 10..13.
- FILL dst=62, len=4, data=0x3C, then COPY src=62, dst=20, len=4 -> writes hit 62,63,0,1 (wrap); COPY takes 8 access cycles; RAM[20..23]=0x3C; done 1 cycle after last write.
- Preload RAM[0..3]=1,2,3,4; COPY src=0, dst=1, len=3 (overlap) -> RAM[1..3]=1,1,1; RAM[0]=1.
- Preload RAM[5..7]=0xF0,0x20,0x01; SUM src=5, len=3 -> result=0x11 (wrapped mod 256); no write_enable ever asserted.
- Commands with len=0 and op=11 -> done in 2nd cycle after accept, no RAM access; err=1 only for op=11; err clears on next accept.
- FILL len=64, reset asserted on 10th write cycle -> exactly 9 locations written; busy=0 and write_enable=0 from next cycle; cmd_ready=1; new command accepted normally.

Source files
------------

// File: rtl/ram_block_mover.sv
// ram_block_mover: block sequencer for the 64x8 data RAM.
// Runs FILL / COPY / SUM commands taken over a valid/ready port. It drives
// the RAM address/write side and reads its combinational output_data.
// All RAM-side outputs come from registers set one cycle ahead. The
// state's access is therefore presented for the whole cycle in that state.
module ram_block_mover #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_src,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] result,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_write_enable,
  output logic [DATA_WIDTH-1:0] ram_input_data,
  input  logic [DATA_WIDTH-1:0] ram_output_data
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    COPY_RD = 3'd2,
    COPY_WR = 3'd3,
    SUM     = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] OP_FILL = 2'b00;
  localparam logic [1:0] OP_COPY = 2'b01;
  localparam logic [1:0] OP_SUM  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [ADDR_WIDTH:0] LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] LEN_ZERO = '0;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   src_reg;
  logic [ADDR_WIDTH-1:0]   dst_reg;
  logic [ADDR_WIDTH:0]     len_reg;
  logic [ADDR_WIDTH:0]     idx_reg;
  logic [DATA_WIDTH-1:0]   result_reg;
  logic                    done_reg;
  logic                    err_reg;
  logic                    we_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  // Holds the FILL value, and doubles as the COPY byte buffer.
  logic [DATA_WIDTH-1:0]   wdata_reg;

  logic                    last_byte;
  logic [ADDR_WIDTH:0]     idx_next;
  logic [ADDR_WIDTH-1:0]   src_next_addr;
  logic [ADDR_WIDTH-1:0]   dst_next_addr;
  logic [ADDR_WIDTH-1:0]   dst_cur_addr;

  // Index bookkeeping; address sums truncate, giving the mod-depth wrap.
  assign last_byte     = (idx_reg == (len_reg - LEN_ONE));
  assign idx_next      = idx_reg + LEN_ONE;
  assign src_next_addr = src_reg + idx_next[ADDR_WIDTH-1:0];
  assign dst_next_addr = dst_reg + idx_next[ADDR_WIDTH-1:0];
  assign dst_cur_addr  = dst_reg + idx_reg[ADDR_WIDTH-1:0];

  // Sequencer FSM: state, counters, result and registered RAM-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      src_reg    <= '0;
      dst_reg    <= '0;
      len_reg    <= '0;
      idx_reg    <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            src_reg <= cmd_src;
            dst_reg <= cmd_dst;
            len_reg <= cmd_len;
            idx_reg <= '0;
            err_reg <= 1'b0;
            if (cmd_op == OP_SUM) begin
              result_reg <= '0;
            end
            if (cmd_op == OP_RSVD) begin
              err_reg  <= 1'b1;
              state    <= DONE;
              done_reg <= 1'b1;
            end else if (cmd_len == LEN_ZERO) begin
              state    <= DONE;
              done_reg <= 1'b1;
            end else begin
              case (cmd_op)
                OP_FILL: begin
                  state     <= FILL;
                  addr_reg  <= cmd_dst;
                  we_reg    <= 1'b1;
                  wdata_reg <= cmd_data;
                end
                OP_COPY: begin
                  state    <= COPY_RD;
                  addr_reg <= cmd_src;
                  we_reg   <= 1'b0;
                end
                default: begin
                  state    <= SUM;
                  addr_reg <= cmd_src;
                  we_reg   <= 1'b0;
                end
              endcase
            end
          end
        end

        FILL: begin
          if (last_byte) begin
            state    <= DONE;
            done_reg <= 1'b1;
            we_reg   <= 1'b0;
          end else begin
            idx_reg  <= idx_next;
            addr_reg <= dst_next_addr;
          end
        end

        COPY_RD: begin
          wdata_reg <= ram_output_data;
          addr_reg  <= dst_cur_addr;
          we_reg    <= 1'b1;
          state     <= COPY_WR;
        end

        COPY_WR: begin
          we_reg <= 1'b0;
          if (last_byte) begin
            state    <= DONE;
            done_reg <= 1'b1;
          end else begin
            idx_reg  <= idx_next;
            addr_reg <= src_next_addr;
            state    <= COPY_RD;
          end
        end

        SUM: begin
          result_reg <= result_reg + ram_output_data;
          if (last_byte) begin
            state    <= DONE;
            done_reg <= 1'b1;
          end else begin
            idx_reg  <= idx_next;
            addr_reg <= src_next_addr;
          end
        end

        DONE: begin
          state     <= IDLE;
          we_reg    <= 1'b0;
          addr_reg  <= '0;
          wdata_reg <= '0;
        end

        default: begin
          state  <= IDLE;
          we_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = (state != IDLE);
  assign cmd_ready      = (state == IDLE);
  assign done           = done_reg;
  assign err            = err_reg;
  assign result         = result_reg;
  assign ram_address    = addr_reg;
  assign ram_input_data = wdata_reg;
  // The RAM samples write_enable on the same edge that applies reset. Gating
  // it here stops a write from landing in the cycle that reset aborts.
  assign ram_write_enable = we_reg & ~reset;

endmodule
